// File: rtl/prog_tick_gen.sv
// Programmable tick generator: periodic, one-shot and PWM modes with a
// wrapping event counter and sticky wrap flag. Period, duty and mode are
// held in shadow registers that only reload while idle, on start, or at
// terminal count, so a reprogram never truncates a running period.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | disarmed; shadows track inputs, cnt held at 0, no ticks
// S_RUN  | armed; cnt advances on en, tick at cnt == Pa-1
module prog_tick_gen #(
  parameter int WIDTH     = 8,
  parameter int EVT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     period,
  input  logic [WIDTH-1:0]     duty,
  input  logic                 clr_evt,
  output logic                 tick,
  output logic                 pwm_out,
  output logic                 busy,
  output logic [EVT_WIDTH-1:0] evt_count,
  output logic                 evt_wrap
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_PWM     = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_s;
  logic [WIDTH-1:0] duty_s;
  logic [1:0]       mode_s;
  logic [WIDTH-1:0] pa;
  logic             terminal;

  // A programmed period of 0 behaves as 1 so the counter always has a terminal value.
  assign pa = (period_s == '0) ? WIDTH'(1) : period_s;

  // Terminal count only advances when running, enabled and no start/stop overrides it.
  assign terminal = (state == S_RUN) && en && !start && !stop
                    && (cnt == (pa - WIDTH'(1)));

  // Sequencer: start beats stop beats the enable freeze beats normal counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      tick     <= 1'b0;
      period_s <= '0;
      duty_s   <= '0;
      mode_s   <= '0;
    end else if (start) begin
      state    <= S_RUN;
      cnt      <= '0;
      tick     <= 1'b0;
      period_s <= period;
      duty_s   <= duty;
      mode_s   <= mode;
    end else if (stop) begin
      state <= S_IDLE;
      cnt   <= '0;
      tick  <= 1'b0;
    end else if (!en) begin
      tick <= 1'b0;
    end else if (state == S_IDLE) begin
      cnt      <= '0;
      tick     <= 1'b0;
      period_s <= period;
      duty_s   <= duty;
      mode_s   <= mode;
    end else if (terminal) begin
      cnt      <= '0;
      tick     <= 1'b1;
      period_s <= period;
      duty_s   <= duty;
      mode_s   <= mode;
      if (mode_s == MODE_ONESHOT) begin
        state <= S_IDLE;
      end
    end else begin
      cnt  <= cnt + WIDTH'(1);
      tick <= 1'b0;
    end
  end

  // Event counter: a clear coinciding with a tick still counts that tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_count <= '0;
      evt_wrap  <= 1'b0;
    end else if (clr_evt) begin
      evt_count <= terminal ? EVT_WIDTH'(1) : '0;
      evt_wrap  <= 1'b0;
    end else if (terminal) begin
      evt_count <= evt_count + EVT_WIDTH'(1);
      if (&evt_count) begin
        evt_wrap <= 1'b1;
      end
    end
  end

  assign busy    = (state == S_RUN);
  assign pwm_out = (state == S_RUN) && (mode_s == MODE_PWM) && (cnt < duty_s);

endmodule

// File: tb/tb_prog_tick_gen.sv
// Directed bench for prog_tick_gen: expected tick cycles are queued when
// stimulus is applied and popped as the DUT produces ticks.
module tb_prog_tick_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] period;
  logic [7:0] duty;
  logic       clr_evt;
  logic       tick;
  logic       pwm_out;
  logic       busy;
  logic [6:0] evt_count;
  logic       evt_wrap;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_q[$];

  prog_tick_gen #(.WIDTH(8), .EVT_WIDTH(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .period    (period),
    .duty      (duty),
    .clr_evt   (clr_evt),
    .tick      (tick),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .evt_count (evt_count),
    .evt_wrap  (evt_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; sample 1 time unit after the edge and score the tick output.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() != 0 && exp_q[0] == cyc) begin
      void'(exp_q.pop_front());
      chk("tick_due", 32'(tick), 32'd1);
    end else if (tick) begin
      chk("tick_spurious", 32'(tick), 32'd0);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_pwm"},  32'(pwm_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_evt"},  32'(evt_count), 32'd0);
    chk({tag, "_wrap"}, 32'(evt_wrap), 32'd0);
  endtask

  initial begin
    int k;
    int k2;
    reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
    mode = 2'b00; period = 8'd0; duty = 8'd0; clr_evt = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    reset = 1'b0;
    en = 1'b1;
    step();

    // Periodic, period 4: ticks 4, 8, 12 cycles after run rises.
    mode = 2'b00; period = 8'd4;
    k = cyc + 1;
    exp_q.push_back(k + 4); exp_q.push_back(k + 8); exp_q.push_back(k + 12);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("per_busy", 32'(busy), 32'd1);
    while (cyc < k + 12) step();
    chk("per_evt3", 32'(evt_count), 32'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("per_stop_busy", 32'(busy), 32'd0);
    chk("per_queue", 32'(exp_q.size()), 32'd0);
    clr_evt = 1'b1;
    step();
    clr_evt = 1'b0;
    chk("clr_evt_idle", 32'(evt_count), 32'd0);

    // One-shot, period 5: single tick, busy drops on the tick edge.
    mode = 2'b01; period = 8'd5;
    k = cyc + 1;
    exp_q.push_back(k + 5);
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < k + 4) step();
    chk("os_busy_before", 32'(busy), 32'd1);
    step();
    chk("os_busy_after", 32'(busy), 32'd0);
    chk("os_evt1", 32'(evt_count), 32'd1);
    repeat (20) step();
    chk("os_still_idle", 32'(busy), 32'd0);
    k = cyc + 1;
    exp_q.push_back(k + 5);
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < k + 5) step();
    chk("os_evt2", 32'(evt_count), 32'd2);
    chk("os_queue", 32'(exp_q.size()), 32'd0);

    // PWM, period 8, duty 3: high for cnt 0..2.
    mode = 2'b10; period = 8'd8; duty = 8'd3;
    k = cyc + 1;
    exp_q.push_back(k + 8); exp_q.push_back(k + 16);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("pwm_d3", 32'(pwm_out), 32'd1);
    while (cyc < k + 16) begin
      step();
      chk("pwm_d3", 32'(pwm_out), (((cyc - k) % 8) < 3) ? 32'd1 : 32'd0);
    end
    duty = 8'd0;
    k = cyc + 1;
    exp_q.push_back(k + 8);
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < k + 8) begin
      step();
      chk("pwm_d0", 32'(pwm_out), 32'd0);
    end
    duty = 8'd10;
    k = cyc + 1;
    exp_q.push_back(k + 8);
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < k + 8) begin
      step();
      chk("pwm_d10", 32'(pwm_out), 32'd1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("pwm_stop", 32'(pwm_out), 32'd0);
    chk("pwm_queue", 32'(exp_q.size()), 32'd0);

    // Reprogram 4 -> 2 mid-period, then stretch by 3 cycles of en low.
    mode = 2'b00; period = 8'd4;
    k = cyc + 1;
    exp_q.push_back(k + 4); exp_q.push_back(k + 6); exp_q.push_back(k + 8);
    exp_q.push_back(k + 13); exp_q.push_back(k + 15);
    start = 1'b1;
    step();
    start = 1'b0;
    period = 8'd2;
    while (cyc < k + 8) step();
    en = 1'b0;
    while (cyc < k + 11) step();
    en = 1'b1;
    while (cyc < k + 15) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("reprog_queue", 32'(exp_q.size()), 32'd0);

    // Event counter wrap with period 1, then clear on a tick edge.
    clr_evt = 1'b1;
    step();
    clr_evt = 1'b0;
    period = 8'd1;
    k = cyc + 1;
    for (int i = 1; i <= 129; i++) exp_q.push_back(k + i);
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < k + 127) step();
    chk("evt_127", 32'(evt_count), 32'd127);
    chk("wrap_before", 32'(evt_wrap), 32'd0);
    step();
    chk("evt_wrap0", 32'(evt_count), 32'd0);
    chk("wrap_set", 32'(evt_wrap), 32'd1);
    clr_evt = 1'b1;
    step();
    clr_evt = 1'b0;
    chk("clr_on_tick_evt", 32'(evt_count), 32'd1);
    chk("clr_on_tick_wrap", 32'(evt_wrap), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("evt_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-count, then stop+start together, then restart on a due tick.
    mode = 2'b10; period = 8'd6; duty = 8'd3;
    k = cyc + 1;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < k + 2) step();
    chk("pre_reset_pwm", 32'(pwm_out), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle_outputs("mid_reset");
    k2 = cyc + 1;
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("stopstart_busy", 32'(busy), 32'd1);
    chk("stopstart_tick", 32'(tick), 32'd0);
    while (cyc < k2 + 5) step();
    k = cyc + 1;
    exp_q.push_back(k + 6);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_suppress", 32'(tick), 32'd0);
    while (cyc < k + 6) step();
    chk("restart_evt", 32'(evt_count), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_tick_gen.md
# prog_tick_gen

Parametrised programmable tick generator with start/stop control, selectable periodic, one-shot and PWM modes, and an event counter with a sticky wrap flag. It produces a one-cycle `tick` every programmed number of enabled clock cycles and counts the ticks. It serves as the shared timebase and rate source for the user-facing pins of the design. Period, duty and mode are double-buffered so reprogramming never produces a truncated period.

## Interface
- `WIDTH`, 8: width of `period`, `duty` and the internal cycle counter.
- `EVT_WIDTH`, 7: width of `evt_count`.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `en`  in  1  global advance enable; 0 freezes all state.
- `start`  in  1  arm/restart; loads shadows, clears cycle counter.
- `stop`  in  1  disarm; the generator returns to idle.
- `mode`  in  2  00 periodic, 01 one-shot, 10 PWM, 11 treated as periodic.
- `period`  in  WIDTH  cycles per tick; 0 treated as 1.
- `duty`  in  WIDTH  PWM high cycles per period.
- `clr_evt`  in  1  clears `evt_count` and `evt_wrap`.
- `tick`  out  1  one-cycle pulse at terminal count (registered).
- `pwm_out`  out  1  PWM waveform.
- `busy`  out  1  generator armed (`run`).
- `evt_count`  out  EVT_WIDTH  ticks since reset or clear, wrapping.
- `evt_wrap`  out  1  sticky; set when `evt_count` wraps.

## Operation
- State: `run`, `cnt[WIDTH]`, shadows `period_s`, `duty_s`, `mode_s`, `evt_count`, `evt_wrap`, `tick`.
- Reset: every register 0. All outputs read 0.
- Effective period `Pa = (period_s == 0) ? 1 : period_s`.
- Idle (`run`=0): shadows track the inputs every edge. `cnt`=0 and `tick`=0.
- `start`=1 at an edge:
  - Sets `run`.
  - Loads the shadows from the inputs.
  - Sets `cnt`<=0 and `tick`<=0.
  - Applies in any state. It takes priority over `stop` and over terminal count on the same edge.
- `stop`=1 without `start`: `run`<=0, `cnt`<=0, `tick`<=0.
- Counting happens when `run`=1, `en`=1, and neither `start` nor `stop` is asserted.
  - If `cnt == Pa-1` (terminal): `cnt`<=0, `tick`<=1, `evt_count` increments, shadows reload from the inputs.
    - In one-shot, `run`<=0 on this same edge.
  - Otherwise: `cnt`<=`cnt`+1 and `tick`<=0.
- `en`=0: `run`, `cnt`, the shadows and the event state hold. `tick`<=0.
- `mode`, `period` and `duty` changes while running take effect only at the next terminal count or `start`.
- `pwm_out = run & (mode_s == 10) & (cnt < duty_s)`. This is decoded from registers only.
  - `duty_s`=0 gives constant 0.
  - `duty_s >= Pa` gives constant 1 while running.
- Event counter:
  - Increments modulo 2^EVT_WIDTH on each tick edge.
  - The wrap from all-ones to 0 sets `evt_wrap`. `evt_wrap` stays set until `clr_evt` or reset.
  - `clr_evt` together with a terminal count on the same edge gives `evt_count`=1 and `evt_wrap`=0.
  - `clr_evt` alone gives 0/0.
- `busy` = `run`.

## Timing
- Take `run` rising at edge k. With `en` held at 1, the first `tick` is high in the cycle after edge k+Pa. Later ticks follow every Pa cycles.
- With Pa=1, `tick` is high every cycle from edge k+1 onward.
- One-shot: exactly one `tick`, Pa cycles after `run` rises. `busy` falls on the same edge that `tick` rises.
- Each cycle with `en`=0 stretches the current period by one cycle.
- `tick` is never high for two consecutive cycles unless Pa=1.
- A `start` while running restarts the period and suppresses any tick due on that edge.
- Reset mid-operation: all outputs are 0 after the reset edge. There is no spurious tick.

## Test plan
- Periodic, period=4, `en`=1, one `start` pulse:
  - `tick` is high in cycles 4, 8, 12 after `run` rises.
  - `evt_count` reaches 3 after the third tick.
- One-shot, period=5:
  - A single `tick` 5 cycles after `start`. `busy` is low from that edge on. No further ticks over 20 cycles.
  - A second `start` produces a second tick.
- PWM, period=8, duty=3:
  - `pwm_out` is high for cnt 0..2 and low for 3..7, repeating.
  - duty=0 gives constant low. duty=10 gives constant high.
- Reprogram period from 4 to 2 mid-period: the current period completes at 4, then ticks come every 2 cycles. `en` low for 3 cycles delays the next tick by 3.
- Event counter with EVT_WIDTH=7, period=1:
  - After 128 ticks, `evt_count`=0 and `evt_wrap`=1.
  - `clr_evt` on a tick edge gives `evt_count`=1 and `evt_wrap`=0.
- Reset asserted mid-count with period=6: the next cycle shows all outputs 0. A `stop`+`start` asserted together restart counting with no tick.
